count_gate_ctrl: RTL and testbench
==================================

# count_gate_ctrl

Measurement-window controller that sits directly upstream of the 16-bit event counter. It clears the counter at the start of a measurement, then issues divided `count_en` ticks for a programmed number of ticks or until stopped. It also records whether the counter wrapped during the window. It signals completion with a one-cycle `done` pulse so that software or a capture stage can read the frozen count.

## Interface
- `PRESCALE_W`, 8 — width of the prescale divider value.
- `WIN_W`, 16 — width of the window length in ticks.

- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `start` in 1 — level sampled each cycle; begins a measurement when in IDLE.
- `stop` in 1 — level sampled each cycle; ends a measurement early when in RUN.
- `prescale` in PRESCALE_W — tick period minus one; a tick occurs every `prescale`+1 RUN cycles.
- `window` in WIN_W — number of ticks per measurement; 0 means free-run until `stop`.
- `ovf_in` in 1 — counter at-maximum flag from the counter's `overflow` output.
- `count_clr` out 1 — counter clear, high for exactly one cycle per measurement.
- `count_en` out 1 — counter increment strobe, one cycle per tick.
- `busy` out 1 — high in CLEAR and RUN.
- `done` out 1 — one-cycle completion pulse.
- `ovf_flag` out 1 — sticky flag: counter wrapped during the current or last window.

## Operation
- FSM states: IDLE → CLEAR → RUN → DONE → IDLE.
- **IDLE**
  - Outputs `count_clr`, `count_en`, `busy` and `done` are 0.
  - `start`=1 → CLEAR.
  - `stop` is ignored in IDLE. If `start` and `stop` are both high, the machine still goes to CLEAR.
- **CLEAR** (exactly 1 cycle)
  - `count_clr`=1, `busy`=1.
  - Latches `prescale`→`pre_q` and `window`→`win_q`.
  - Zeroes the prescale counter `pcnt` and the tick counter `tcnt`.
  - Clears `ovf_flag`.
  - Always → RUN.
- **RUN**
  - `busy`=1.
  - `pcnt` increments each cycle. When `pcnt`==`pre_q`: `count_en`=1, `pcnt`←0, `tcnt`←`tcnt`+1.
  - `pre_q`=0 gives `count_en` on every RUN cycle.
  - → DONE when `stop`=1, or when `win_q`≠0 and `tcnt`+1==`win_q` on a tick cycle.
  - On the `stop` cycle, a tick still fires if it is due that cycle. Then → DONE.
  - `start` is ignored in RUN.
- **DONE** (exactly 1 cycle)
  - `done`=1, `busy`=0.
  - Always → IDLE. A `start` asserted during DONE takes effect only once the machine is back in IDLE.
- **ovf_flag**: set when `count_en`=1 and `ovf_in`=1, i.e. this tick wraps the counter. It holds until the next CLEAR.
- **Arithmetic**
  - `pcnt` is PRESCALE_W bits, `tcnt` is WIN_W bits.
  - In free-run mode (`win_q`=0), `tcnt` wraps silently and the window never ends on tick count.
- `prescale` and `window` changes mid-measurement have no effect. The values latched in CLEAR are used.
- **Reset** (including mid-measurement): state=IDLE. `pcnt`, `tcnt`, `pre_q`, `win_q` and `ovf_flag` go to 0. All outputs are 0 while reset is held and immediately after release.

## Timing
- All outputs are decoded from registered state, `pcnt` and `pre_q`. There is no combinational path from an input to an output.
- `start` sampled high in cycle 0 (IDLE) gives:
  - `count_clr` in cycle 1;
  - first RUN cycle in cycle 2;
  - first `count_en` in cycle 2+P, where P=`pre_q`.
- Tick k (k=0..W−1) occurs in cycle 2+k(P+1)+P. The last tick is in cycle 1+W(P+1).
- `done` is in cycle 2+W(P+1), with W=`win_q`. IDLE resumes the following cycle, and the earliest restart `start` is sampled in that cycle.
- `stop` sampled high in RUN cycle n gives `done` in cycle n+1.
- Exactly W `count_en` pulses are issued per completed window.

## Structure
- Shared package `counter_pkg` holds:
  - FSM state encoding constants (IDLE, CLEAR, RUN, DONE; 2 bits);
  - the default width constants `CNT_W` and `PRESCALE_W`.
- One sub-module, `tick_prescaler`:
  - contains `pcnt` and the compare to `pre_q`;
  - inputs: clear and enable;
  - output: `tick`.
- The FSM, `tcnt` and `ovf_flag` stay in the top level.

## Test plan
- **Reset:** assert `rst` mid-RUN with `prescale`=3, `window`=10 → within the same cycle all outputs are 0 and state is IDLE; after release, no `count_en` until a new `start`.
- **Basic window:** `prescale`=3, `window`=4, `start` pulse in cycle 0 → `count_clr` in cycle 1, `count_en` in cycles 5, 9, 13, 17, `done` in cycle 18, `busy` in cycles 1–17.
- **Undivided rate:** `prescale`=0, `window`=1 → `count_en` in cycle 2 only, `done` in cycle 3; the counter reads 1.
- **Early stop with free-run:** `window`=0, `prescale`=1, `stop` in cycle 9 → `count_en` in cycles 3, 5, 7, 9; `done` in cycle 10; `start`+`stop` together in IDLE still begins a measurement.
- **Overflow:** `prescale`=0, `window`=0, counter CNT_W=16 connected; run 65536 ticks → `ovf_flag` rises after the 65536th `count_en`, persists through `done`, and clears on the next CLEAR.
- **Parameter latching:** change `prescale` from 2 to 7 in cycle 5 of a running window → tick spacing stays at 3 cycles until `done`.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared definitions for the event-counter slice: default widths and the
//   state encoding of the measurement-window controller.
//   No ports; imported by count_gate_ctrl and tick_prescaler.

package counter_pkg;

    // Default width of the downstream event counter.
    localparam int CNT_W      = 16;
    // Default width of the prescale divider value.
    localparam int PRESCALE_W = 8;
    // Default width of the window length, in ticks.
    localparam int WIN_W      = 16;

    // Measurement-window controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
//   Divides the RUN-state cycle stream down to one tick every pre+1 cycles.
//   Ports:
//     clk, rst  - clock and asynchronous active-high reset
//     clear     - zero the divider count (used while the window is set up)
//     enable    - count this cycle (high only while measuring)
//     pre       - latched divider value (tick period minus one)
//     tick      - high on the cycle the divider count reaches pre

module tick_prescaler #(
    parameter int PRESCALE_W = counter_pkg::PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] pre,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt_q;
    logic [PRESCALE_W-1:0] pcnt_d;

    // The tick is decoded purely from registered values, so it never
    // depends combinationally on an external input.
    assign tick = enable && (pcnt_q == pre);

    always_comb begin
        pcnt_d = pcnt_q;
        if (clear) begin
            pcnt_d = '0;
        end else if (enable) begin
            if (tick) begin
                pcnt_d = '0;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/count_gate_ctrl.sv
// count_gate_ctrl
//   Measurement-window controller placed in front of the event counter.
//   A start clears the counter, then divided count_en ticks are issued for
//   a programmed number of ticks (or until stop), and a one-cycle done
//   pulse marks the point where the counter value is frozen.
//   Ports:
//     clk, rst   - clock and asynchronous active-high reset
//     start      - begin a measurement (honoured in IDLE only)
//     stop       - end a measurement early (honoured in RUN only)
//     prescale   - tick period minus one, latched at measurement start
//     window     - ticks per measurement, 0 = run until stop; latched
//     ovf_in     - counter is at its maximum value
//     count_clr  - counter clear, one cycle per measurement
//     count_en   - counter increment strobe, one cycle per tick
//     busy       - measurement in progress (CLEAR or RUN)
//     done       - one-cycle completion pulse
//     ovf_flag   - counter wrapped during the current or last window

module count_gate_ctrl #(
    parameter int PRESCALE_W = counter_pkg::PRESCALE_W,
    parameter int WIN_W      = counter_pkg::WIN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIN_W-1:0]      window,
    input  logic                  ovf_in,
    output logic                  count_clr,
    output logic                  count_en,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf_flag
);

    import counter_pkg::*;

    localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

    state_t                state_q;
    state_t                state_d;
    logic [PRESCALE_W-1:0] pre_q;
    logic [PRESCALE_W-1:0] pre_d;
    logic [WIN_W-1:0]      win_q;
    logic [WIN_W-1:0]      win_d;
    logic [WIN_W-1:0]      tcnt_q;
    logic [WIN_W-1:0]      tcnt_d;
    logic                  ovf_flag_q;
    logic                  ovf_flag_d;

    logic                  in_clear;
    logic                  in_run;
    logic                  tick;
    logic                  window_end;

    assign in_clear = (state_q == ST_CLEAR);
    assign in_run   = (state_q == ST_RUN);

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clear  (in_clear),
        .enable (in_run),
        .pre    (pre_q),
        .tick   (tick)
    );

    // A window of zero means free-run: the tick count wraps silently and
    // never terminates the measurement on its own.
    assign window_end = (win_q != '0) && tick && ((tcnt_q + WIN_ONE) == win_q);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Start wins over stop in IDLE; start is ignored in
    // RUN and DONE, so a start during DONE only counts once back in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop || window_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only. A tick due on the stop
    // cycle still fires because count_en does not look at stop.
    always_comb begin
        count_clr = in_clear;
        count_en  = tick;
        busy      = in_clear || in_run;
        done      = (state_q == ST_DONE);
        ovf_flag  = ovf_flag_q;
    end

    // Window parameters are captured once in CLEAR so later changes on the
    // inputs cannot disturb a running measurement. The overflow flag is
    // sticky from the wrapping tick until the next CLEAR.
    always_comb begin
        pre_d      = pre_q;
        win_d      = win_q;
        tcnt_d     = tcnt_q;
        ovf_flag_d = ovf_flag_q;
        if (in_clear) begin
            pre_d      = prescale;
            win_d      = window;
            tcnt_d     = '0;
            ovf_flag_d = 1'b0;
        end else if (tick) begin
            tcnt_d = tcnt_q + WIN_ONE;
            if (ovf_in) begin
                ovf_flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q      <= '0;
            win_q      <= '0;
            tcnt_q     <= '0;
            ovf_flag_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            win_q      <= win_d;
            tcnt_q     <= tcnt_d;
            ovf_flag_q <= ovf_flag_d;
        end
    end

endmodule

// File: tb/tb_count_gate_ctrl.sv
// tb_count_gate_ctrl
//   Directed bench for count_gate_ctrl with a behavioural 16-bit event
//   counter attached to count_clr/count_en/ovf_in.

module tb_count_gate_ctrl;

    import counter_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  prescale = 8'd0;
    logic [15:0] window = 16'd0;
    logic        ovfIn;
    logic        countClr;
    logic        countEn;
    logic        busy;
    logic        done;
    logic        ovfFlag;

    logic [15:0] eventCount;

    int testsRun = 0;
    int testsFailed = 0;

    logic [63:0] enTrace;
    logic [63:0] clrTrace;
    logic [63:0] busyTrace;
    logic [63:0] doneTrace;

    count_gate_ctrl #(
        .PRESCALE_W (8),
        .WIN_W      (16)
    ) dut (
        .clk       (clock),
        .rst       (reset),
        .start     (start),
        .stop      (stop),
        .prescale  (prescale),
        .window    (window),
        .ovf_in    (ovfIn),
        .count_clr (countClr),
        .count_en  (countEn),
        .busy      (busy),
        .done      (done),
        .ovf_flag  (ovfFlag)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    // Behavioural event counter standing in for the real 16-bit counter.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            eventCount <= 16'd0;
        end else if (countClr) begin
            eventCount <= 16'd0;
        end else if (countEn) begin
            eventCount <= eventCount + 16'd1;
        end
    end

    assign ovfIn = (eventCount == 16'hFFFF);

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] spanBits(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) begin
            m[i] = 1'b1;
        end
        return m;
    endfunction

    // Starts a measurement in cycle 0 and records the outputs of cycles
    // 0..nCycles. stop is raised in stopCycle (and in cycle 0 as well when
    // stopWithStart is set); prescale changes to newPre in changeCycle.
    task automatic applyStimulus(input logic [7:0] pre, input logic [15:0] win,
                                 input int stopCycle, input bit stopWithStart,
                                 input int changeCycle, input logic [7:0] newPre,
                                 input int nCycles);
        enTrace   = '0;
        clrTrace  = '0;
        busyTrace = '0;
        doneTrace = '0;
        @(negedge clock);
        enTrace[0]   = countEn;
        clrTrace[0]  = countClr;
        busyTrace[0] = busy;
        doneTrace[0] = done;
        prescale = pre;
        window   = win;
        start    = 1'b1;
        stop     = stopWithStart;
        for (int k = 1; k <= nCycles; k++) begin
            @(negedge clock);
            enTrace[k]   = countEn;
            clrTrace[k]  = countClr;
            busyTrace[k] = busy;
            doneTrace[k] = done;
            start = 1'b0;
            stop  = (k == stopCycle);
            if (k == changeCycle) begin
                prescale = newPre;
            end
        end
        stop = 1'b0;
    endtask

    initial begin
        int ticks;
        int cycles;
        logic [63:0] seen;

        // Outputs while reset is held and right after release.
        @(negedge clock);
        checkOutput("outputs in reset", 64'({countClr, countEn, busy, done, ovfFlag}), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("outputs after release", 64'({countClr, countEn, busy, done, ovfFlag}), 64'd0);

        // Basic window: prescale 3, window 4.
        applyStimulus(8'd3, 16'd4, -1, 1'b0, -1, 8'd0, 22);
        checkOutput("basic count_en", enTrace, 64'h0000_0000_0002_2220);
        checkOutput("basic count_clr", clrTrace, 64'h2);
        checkOutput("basic busy", busyTrace, spanBits(1, 17));
        checkOutput("basic done", doneTrace, 64'h0000_0000_0004_0000);
        checkOutput("basic counter", 64'(eventCount), 64'd4);

        // Undivided rate: prescale 0, window 1.
        applyStimulus(8'd0, 16'd1, -1, 1'b0, -1, 8'd0, 6);
        checkOutput("undiv count_en", enTrace, 64'h4);
        checkOutput("undiv count_clr", clrTrace, 64'h2);
        checkOutput("undiv busy", busyTrace, spanBits(1, 2));
        checkOutput("undiv done", doneTrace, 64'h8);
        checkOutput("undiv counter", 64'(eventCount), 64'd1);

        // Free-run with early stop; start and stop together in IDLE.
        applyStimulus(8'd1, 16'd0, 9, 1'b1, -1, 8'd0, 14);
        checkOutput("stop count_en", enTrace, 64'h2A8);
        checkOutput("stop count_clr", clrTrace, 64'h2);
        checkOutput("stop busy", busyTrace, spanBits(1, 9));
        checkOutput("stop done", doneTrace, 64'h400);
        checkOutput("stop counter", 64'(eventCount), 64'd4);

        // Parameter latching: prescale changes 2 -> 7 mid-window.
        applyStimulus(8'd2, 16'd4, -1, 1'b0, 5, 8'd7, 18);
        checkOutput("latch count_en", enTrace, 64'h2490);
        checkOutput("latch busy", busyTrace, spanBits(1, 13));
        checkOutput("latch done", doneTrace, 64'h4000);
        checkOutput("latch counter", 64'(eventCount), 64'd4);

        // Reset in the middle of RUN, on a tick cycle.
        @(negedge clock);
        prescale = 8'd3;
        window   = 16'd10;
        start    = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            start = 1'b0;
        end
        checkOutput("pre-reset count_en", 64'(countEn), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid-run reset outputs", 64'({countClr, countEn, busy, done, ovfFlag}), 64'd0);
        checkOutput("mid-run reset state", 64'(dut.state_q), 64'(ST_IDLE));
        @(negedge clock);
        reset = 1'b0;
        seen = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            seen[0] = seen[0] | countEn;
            seen[1] = seen[1] | busy;
            seen[2] = seen[2] | countClr;
        end
        checkOutput("idle after reset", seen, 64'd0);

        // Overflow: 65536 undivided ticks in free-run mode.
        @(negedge clock);
        prescale = 8'd0;
        window   = 16'd0;
        start    = 1'b1;
        ticks  = 0;
        cycles = 0;
        while (ticks < 65536 && cycles < 70000) begin
            @(negedge clock);
            start = 1'b0;
            cycles++;
            if (countEn) begin
                ticks++;
            end
        end
        checkOutput("ovf tick budget", 64'(ticks), 64'd65536);
        checkOutput("ovf_in on wrap tick", 64'(ovfIn), 64'd1);
        checkOutput("ovf_flag before wrap", 64'(ovfFlag), 64'd0);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        checkOutput("ovf done pulse", 64'(done), 64'd1);
        checkOutput("ovf_flag at done", 64'(ovfFlag), 64'd1);
        checkOutput("ovf wrapped counter", 64'(eventCount), 64'd0);
        @(negedge clock);
        checkOutput("ovf_flag in idle", 64'(ovfFlag), 64'd1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checkOutput("restart count_clr", 64'(countClr), 64'd1);
        checkOutput("ovf_flag during clear", 64'(ovfFlag), 64'd1);
        @(negedge clock);
        checkOutput("ovf_flag after clear", 64'(ovfFlag), 64'd0);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        checkOutput("final done", 64'(done), 64'd1);
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
